// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory controller: size codes, FSM states
// and the endian-aware lane extract/merge helpers.
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   function automatic logic [31:0] lane_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 32'h0000_00FF;
         SZ_HALF: return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Bit position of the lane LSB inside the word; misaligned halves give a
   // harmless value because those accesses fault before the result is used.
   function automatic logic [4:0] lane_shift(input logic [1:0] offset,
                                             input logic [1:0] size,
                                             input logic       big_endian);
      logic [4:0] off_bits;
      off_bits = {offset, 3'b000};
      if (size == SZ_WORD || size == SZ_RSVD) return 5'd0;
      if (!big_endian) return off_bits;
      return (size == SZ_BYTE) ? (5'd24 - off_bits) : (5'd16 - off_bits);
   endfunction

   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [1:0]  size,
                                                input logic        big_endian);
      return (word >> lane_shift(offset, size, big_endian)) & lane_mask(size);
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  offset,
                                              input logic [1:0]  size,
                                              input logic        big_endian);
      logic [4:0]  sh;
      logic [31:0] m;
      sh = lane_shift(offset, size, big_endian);
      m  = lane_mask(size) << sh;
      return (word & ~m) | ((wdata << sh) & m);
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane steering: store merge word, extended load data and the
// alignment check for the captured access.
module dmem_lane_unit
   import mips_mem_pkg::*;
#(
   parameter int BIG_ENDIAN = 1
)
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [31:0] merge_data,
   output logic [31:0] load_data,
   output logic        misalign
);

   localparam logic BE = (BIG_ENDIAN != 0);

   logic [31:0] lane;

   always_comb begin
      lane       = lane_extract(rword, offset, size, BE);
      merge_data = lane_merge(rword, wdata, offset, size, BE);
      case (size)
         SZ_BYTE: load_data = is_unsigned ? {24'd0, lane[7:0]}
                                          : {{24{lane[7]}}, lane[7:0]};
         SZ_HALF: load_data = is_unsigned ? {16'd0, lane[15:0]}
                                          : {{16{lane[15]}}, lane[15:0]};
         default: load_data = lane;
      endcase
      misalign = ((size == SZ_HALF) && offset[0]) ||
                 ((size == SZ_WORD) && (offset != 2'b00));
   end

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Byte-addressed data memory with one outstanding request, LATENCY cycles from
// acceptance to response; response held until resp_ready, req_ready only in IDLE.
module mips_dmem_ctrl
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 1,
   parameter int BIG_ENDIAN  = 1,
   parameter int FCNT_W      = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic [FCNT_W-1:0] fault_count
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t state, state_nxt;

   logic          write_q;
   logic [1:0]    size_q;
   logic          unsigned_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [CW-1:0] cnt_q;

   logic          accept;
   logic          commit;
   logic          in_range;
   logic          misalign;
   logic          fault;
   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word;
   logic [31:0]   merge_data;
   logic [31:0]   load_data;

   logic [31:0]   mem [DEPTH_WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid)            state_nxt = ST_WAIT;
         ST_WAIT: if (cnt_q == '0)          state_nxt = ST_RESP;
         ST_RESP: if (resp_ready)           state_nxt = ST_IDLE;
         default:                           state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == ST_IDLE);
      resp_valid = (state == ST_RESP);
      accept     = (state == ST_IDLE) && req_valid;
      commit     = (state == ST_WAIT) && (cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q    <= 1'b0;
         size_q     <= SZ_BYTE;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
      end else if (accept) begin
         write_q    <= req_write;
         size_q     <= req_size;
         unsigned_q <= req_unsigned;
         addr_q     <= req_addr;
         wdata_q    <= req_wdata;
         cnt_q      <= CW'(LATENCY - 1);
      end else if (state == ST_WAIT && cnt_q != '0) begin
         cnt_q      <= cnt_q - CW'(1);
      end
   end

   // Out-of-range indices are steered to word 0 so the array read stays in bounds.
   always_comb begin
      in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
      word_idx = in_range ? addr_q[AW+1:2] : '0;
      fault    = !in_range || (size_q == SZ_RSVD) || misalign;
   end

   assign rd_word = mem[word_idx];

   dmem_lane_unit #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane (
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .wdata       (wdata_q),
      .rword       (rd_word),
      .merge_data  (merge_data),
      .load_data   (load_data),
      .misalign    (misalign)
   );

   always_ff @(posedge clk) begin
      if (commit && write_q && !fault) mem[word_idx] <= merge_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_rdata  <= '0;
         resp_fault  <= 1'b0;
         fault_count <= '0;
      end else if (commit) begin
         resp_rdata <= (fault || write_q) ? 32'd0 : load_data;
         resp_fault <= fault;
         if (fault && fault_count != {FCNT_W{1'b1}})
            fault_count <= fault_count + FCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Bench for mips_dmem_ctrl: a big-endian LATENCY=1 instance and a little-endian
// LATENCY=4 instance, driven from a vector table, corner sequences and random traffic.
module tb_mips_dmem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid    [2];
   logic        req_ready    [2];
   logic        req_write    [2];
   logic [1:0]  req_size     [2];
   logic        req_unsigned [2];
   logic [31:0] req_addr     [2];
   logic [31:0] req_wdata    [2];
   logic        resp_valid   [2];
   logic        resp_ready   [2];
   logic [31:0] resp_rdata   [2];
   logic        resp_fault   [2];
   logic [1:0]  fc0;
   logic [7:0]  fc1;

   int tests = 0;
   int fails = 0;

   logic [7:0] mdl_mem [2][1024];
   int         mdl_fc  [2];

   mips_dmem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1), .BIG_ENDIAN(1), .FCNT_W(2)) dut_be (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]), .fault_count(fc0)
   );

   mips_dmem_ctrl #(.DEPTH_WORDS(100), .LATENCY(4), .BIG_ENDIAN(0), .FCNT_W(8)) dut_le (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]), .fault_count(fc1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int lat_of(input int d);  return (d != 0) ? 4 : 1;     endfunction
   function automatic int dep_of(input int d);  return (d != 0) ? 100 : 256; endfunction
   function automatic bit be_of(input int d);   return (d == 0);             endfunction
   function automatic int fmax_of(input int d); return (d != 0) ? 255 : 3;   endfunction
   function automatic logic [31:0] fc_of(input int d);
      return (d != 0) ? 32'(fc1) : 32'(fc0);
   endfunction

   // Reference model: memory as a flat byte array, accesses as byte sequences.
   function automatic bit mdl_fault(input int d, input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b11) return 1'b1;
      if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
      if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
      if ((a >> 2) >= 32'(dep_of(d))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] mdl_load(input int d, input logic [1:0] sz, input bit uns,
                                            input logic [31:0] a);
      int n;
      logic [31:0] v;
      n = 1 << sz;
      v = 32'd0;
      for (int i = 0; i < n; i++) begin
         if (be_of(d)) v = (v << 8) | 32'(mdl_mem[d][a + i]);
         else          v = v | (32'(mdl_mem[d][a + i]) << (8 * i));
      end
      if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic mdl_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
      int n;
      logic [31:0] t;
      n = 1 << sz;
      for (int i = 0; i < n; i++) begin
         t = be_of(d) ? (wd >> (8 * (n - 1 - i))) : (wd >> (8 * i));
         mdl_mem[d][a + i] = t[7:0];
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_req(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input bit keepv,
                         output logic [31:0] rdata, output logic fault, output int lat);
      int n;
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) chk("ready_wait_timeout", 32'(n), 32'd0);
      req_write[d]    = wr;
      req_size[d]     = sz;
      req_unsigned[d] = uns;
      req_addr[d]     = addr;
      req_wdata[d]    = wdata;
      req_valid[d]    = 1'b1;
      resp_ready[d]   = (hold == 0);
      @(posedge clk); #1;
      if (keepv) begin
         req_addr[d]  = addr ^ 32'h4;
         req_wdata[d] = ~wdata;
         req_write[d] = ~wr;
      end else begin
         req_valid[d] = 1'b0;
      end
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (resp_valid[d] !== 1'b1 && lat < 50);
      rdata = resp_rdata[d];
      fault = resp_fault[d];
      chk("ready_low_in_resp", 32'(req_ready[d]), 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(resp_valid[d]), 32'd1);
         chk("hold_rdata", resp_rdata[d], rdata);
         chk("hold_fault", 32'(resp_fault[d]), 32'(fault));
         chk("hold_ready", 32'(req_ready[d]), 32'd0);
      end
      resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      req_valid[d]  = 1'b0;
      resp_ready[d] = 1'b0;
      chk("valid_after_take", 32'(resp_valid[d]), 32'd0);
      chk("ready_after_take", 32'(req_ready[d]), 32'd1);
   endtask

   task automatic xact(input string name, input int d, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input bit exp_fault,
                       input int hold, input bit keepv);
      logic [31:0] rd;
      logic        f;
      int          lat;
      bit          mf;
      do_req(d, wr, sz, uns, addr, wdata, hold, keepv, rd, f, lat);
      chk({name, "_lat"}, 32'(lat), 32'(lat_of(d)));
      chk({name, "_rdata"}, rd, exp_rdata);
      chk({name, "_fault"}, 32'(f), 32'(exp_fault));
      mf = mdl_fault(d, sz, addr);
      if (!mf && wr) mdl_store(d, sz, addr, wdata);
      if (mf && mdl_fc[d] < fmax_of(d)) mdl_fc[d]++;
      chk({name, "_fcnt"}, fc_of(d), 32'(mdl_fc[d]));
   endtask

   typedef struct {
      int          d;
      bit          wr;
      logic [1:0]  sz;
      bit          uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_fault;
   } vec_t;

   function automatic vec_t mk(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input bit exp_fault);
      vec_t v;
      v.d = d; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_fault = exp_fault;
      return v;
   endfunction

   initial begin
      vec_t        tbl [$];
      logic [1:0]  exp_sat [4];
      logic [31:0] a, wd, er;
      logic [1:0]  sz;
      bit          wr, uns, ef;
      int          d, sel;

      // BE instance: words, byte lanes, halves, misalignment, reserved size
      tbl.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0));
      tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0));
      tbl.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0,        0));
      tbl.push_back(mk(0, 1, 2'b00, 0, 32'h12, 32'hFFFFFFAA, 32'h0,        0));
      tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h1122AA44, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 32'h12, 32'h0,        32'hFFFFFFAA, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 32'h12, 32'h0,        32'h000000AA, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 32'h11, 32'h0,        32'h00000022, 0));
      tbl.push_back(mk(0, 0, 2'b01, 1, 32'h10, 32'h0,        32'h00001122, 0));
      tbl.push_back(mk(0, 0, 2'b01, 0, 32'h11, 32'h0,        32'h0,        1));
      tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h1122AA44, 0));
      tbl.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h0000FFFE, 32'h0,        0));
      tbl.push_back(mk(0, 0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFFFFE, 0));
      tbl.push_back(mk(0, 0, 2'b01, 0, 32'h10, 32'h0,        32'h00000000, 0));
      tbl.push_back(mk(0, 1, 2'b01, 0, 32'h10, 32'h12348001, 32'h0,        0));
      tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h8001FFFE, 0));
      tbl.push_back(mk(0, 1, 2'b11, 0, 32'h14, 32'h12345678, 32'h0,        1));
      tbl.push_back(mk(0, 1, 2'b10, 0, 32'h16, 32'h12345678, 32'h0,        1));
      // LE instance, non-power-of-2 depth
      tbl.push_back(mk(1, 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0,        0));
      tbl.push_back(mk(1, 1, 2'b00, 0, 32'h21, 32'h000000BB, 32'h0,        0));
      tbl.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h1122BB44, 0));
      tbl.push_back(mk(1, 0, 2'b00, 0, 32'h21, 32'h0,        32'hFFFFFFBB, 0));
      tbl.push_back(mk(1, 0, 2'b01, 1, 32'h22, 32'h0,        32'h00001122, 0));
      tbl.push_back(mk(1, 1, 2'b01, 0, 32'h22, 32'h0000ABCD, 32'h0,        0));
      tbl.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        32'hABCDBB44, 0));
      tbl.push_back(mk(1, 0, 2'b01, 0, 32'h22, 32'h0,        32'hFFFFABCD, 0));
      tbl.push_back(mk(1, 0, 2'b00, 1, 32'h23, 32'h0,        32'h000000AB, 0));
      tbl.push_back(mk(1, 0, 2'b10, 0, 32'h190, 32'h0,       32'h0,        1));
      tbl.push_back(mk(1, 1, 2'b10, 0, 32'h18C, 32'hCAFEF00D, 32'h0,       0));
      tbl.push_back(mk(1, 0, 2'b10, 0, 32'h18C, 32'h0,       32'hCAFEF00D, 0));
      tbl.push_back(mk(1, 1, 2'b01, 0, 32'h23, 32'h0000FFFF, 32'h0,        1));

      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = 2'b00;
         req_unsigned[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
         resp_ready[i] = 1'b0; mdl_fc[i] = 0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_req_ready",  32'(req_ready[i]),  32'd1);
         chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
         chk("rst_resp_rdata", resp_rdata[i],      32'd0);
         chk("rst_resp_fault", 32'(resp_fault[i]), 32'd0);
         chk("rst_fault_count", fc_of(i),          32'd0);
      end

      for (int i = 0; i < tbl.size(); i++)
         xact($sformatf("tbl%0d", i), tbl[i].d, tbl[i].wr, tbl[i].sz, tbl[i].uns,
              tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_fault, 0, 0);

      // Reset while a store is waiting to commit: the store must be lost.
      xact("mid_pre", 1, 1, 2'b10, 0, 32'h20, 32'h12345678, 32'h0, 0, 0, 0);
      @(negedge clk);
      req_write[1] = 1'b1; req_size[1] = 2'b00; req_unsigned[1] = 1'b0;
      req_addr[1] = 32'h20; req_wdata[1] = 32'h55; req_valid[1] = 1'b1;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("mid_ready_in_wait", 32'(req_ready[1]), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(resp_valid[1]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mdl_fc[0] = 0; mdl_fc[1] = 0;
      @(posedge clk); #1;
      chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
      chk("mid_rst_fc0", fc_of(0), 32'd0);
      chk("mid_rst_fc1", fc_of(1), 32'd0);
      xact("mid_post", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h12345678, 0, 0, 0);

      // Saturating fault counter on the 2-bit instance.
      exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3;
      for (int k = 0; k < 4; k++) begin
         xact($sformatf("sat%0d", k), 0, 0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1, 0, 0);
         chk($sformatf("sat%0d_fc", k), 32'(fc0), 32'(exp_sat[k]));
      end

      // Backpressure and a request held high across the whole transaction.
      xact("bp_le", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h12345678, 0, 3, 1);
      xact("bp_be", 0, 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000FFFE, 0, 2, 1);

      for (int dd = 0; dd < 2; dd++)
         for (int w = 0; w < 16; w++)
            xact("init", dd, 1, 2'b10, 0, 32'(w * 4), $urandom, 32'h0, 0, 0, 0);

      for (int n = 0; n < 300; n++) begin
         d   = int'($urandom_range(0, 1));
         wr  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         wd  = $urandom;
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      a = 32'(dep_of(d) * 4) + 32'($urandom_range(0, 63));
         else if (sel == 1) a = $urandom | 32'h8000_0000;
         else               a = 32'($urandom_range(0, 63));
         ef = mdl_fault(d, sz, a);
         er = (ef || wr) ? 32'd0 : mdl_load(d, sz, uns, a);
         xact("rand", d, wr, sz, uns, a, wd, er, ef,
              int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 2)) : 0,
              1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
